// File: rtl/inst_fetch_queue_pkg.sv
// =============================================================================
// Module : inst_fetch_queue_pkg
// Brief  : Shared types and constants for the instruction fetch queue.
// Rev    : 1.0
// =============================================================================
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package inst_fetch_queue_pkg;

    localparam int IFQ_DEPTH      = 4;
    localparam int IFQ_ADDR_WIDTH = `ADDR_WIDTH;
    localparam int IFQ_DATA_WIDTH = `DATA_WIDTH;

    typedef struct packed {
        logic [IFQ_ADDR_WIDTH-1:0] pc;
        logic [IFQ_DATA_WIDTH-1:0] inst;
    } ifq_entry_t;

    // Pointer carries one extra wrap bit so full and empty can be told apart.
    function automatic int ifq_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch_queue_if.sv
// =============================================================================
// Module : inst_fetch_queue_if
// Brief  : Enqueue/dequeue handshake bundle between i-cache, queue and decode.
// Rev    : 1.0
// =============================================================================
`default_nettype none

interface inst_fetch_queue_if
    import inst_fetch_queue_pkg::*;
#(
    parameter int ADDR_WIDTH = IFQ_ADDR_WIDTH,
    parameter int DATA_WIDTH = IFQ_DATA_WIDTH,
    parameter int DEPTH      = IFQ_DEPTH
);
    logic                      flush;
    logic                      enq_valid;
    logic [ADDR_WIDTH-1:0]     enq_pc;
    logic [DATA_WIDTH-1:0]     enq_inst;
    logic                      enq_ready;
    logic                      deq_valid;
    logic [ADDR_WIDTH-1:0]     deq_pc;
    logic [DATA_WIDTH-1:0]     deq_inst;
    logic                      deq_ready;
    logic [$clog2(DEPTH):0]    count;

    modport master (
        output flush, enq_valid, enq_pc, enq_inst, deq_ready,
        input  enq_ready, deq_valid, deq_pc, deq_inst, count
    );

    modport slave (
        input  flush, enq_valid, enq_pc, enq_inst, deq_ready,
        output enq_ready, deq_valid, deq_pc, deq_inst, count
    );
endinterface

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// =============================================================================
// Module : inst_fetch_queue
// Brief  : In-order {pc, inst} FIFO between i-cache and decode, with flush.
//          Optional empty-queue bypass when IFQ_BYPASS_EN is defined.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH      = IFQ_DEPTH,
    parameter int ADDR_WIDTH = IFQ_ADDR_WIDTH,
    parameter int DATA_WIDTH = IFQ_DATA_WIDTH
)(
    input  wire logic          clk,
    input  wire logic          rst_n,
    inst_fetch_queue_if.slave  bus
);

    localparam int PTR_W = ifq_ptr_width(DEPTH);
    localparam int IDX_W = PTR_W - 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_count;

    logic               w_empty;
    logic               w_full;
    logic               w_bypass;
    logic               w_enq_fire;
    logic               w_deq_fire;
    logic               w_wr;
    logic               w_rd;
    entry_t             w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                     (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
    assign w_head  = r_mem[r_rd_ptr[IDX_W-1:0]];

`ifdef IFQ_BYPASS_EN
    assign w_bypass = w_empty & bus.enq_valid & ~bus.flush;
`else
    assign w_bypass = 1'b0;
`endif

    // enq_ready depends on registered count only, never on deq_ready.
    assign bus.enq_ready = (r_count != PTR_W'(DEPTH));
    assign bus.count     = r_count;

    always_comb begin
        bus.deq_valid = 1'b0;
        bus.deq_pc    = '0;
        bus.deq_inst  = '0;
        if (w_bypass) begin
            bus.deq_valid = 1'b1;
            bus.deq_pc    = bus.enq_pc;
            bus.deq_inst  = bus.enq_inst;
        end else if (!w_empty) begin
            bus.deq_valid = 1'b1;
            bus.deq_pc    = w_head.pc;
            bus.deq_inst  = w_head.inst;
        end
    end

    assign w_enq_fire = bus.enq_valid & bus.enq_ready & ~bus.flush;
    assign w_deq_fire = bus.deq_valid & bus.deq_ready & ~bus.flush;

    // A bypassed entry consumed in the same cycle never touches storage.
    assign w_wr = w_enq_fire & ~(w_bypass & bus.deq_ready);
    assign w_rd = w_deq_fire & ~w_bypass;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[IDX_W-1:0]] <= '{pc: bus.enq_pc, inst: bus.enq_inst};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + PTR_W'(1);
                2'b01:   r_count <= r_count - PTR_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_no_enq_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_wr && w_full));
    a_no_deq_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_rd && w_empty));
    a_count_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= PTR_W'(DEPTH));
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// =============================================================================
// Module : tb_inst_fetch_queue
// Brief  : Directed table-driven bench for inst_fetch_queue (DEPTH=4).
// Rev    : 1.0
// =============================================================================
`default_nettype none

module tb_inst_fetch_queue;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    inst_fetch_queue_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) u_if ();

    inst_fetch_queue #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        enq_valid;
        logic [31:0] enq_pc;
        logic [31:0] enq_inst;
        logic        deq_ready;
        logic        byp;        // queue empty with a live enq: bypass-visible row
        logic        exp_enq_ready;
        logic        exp_deq_valid;
        logic [31:0] exp_deq_pc;
        logic [31:0] exp_deq_inst;
        logic [2:0]  exp_count;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic ev, input logic [31:0] pc,
                         input logic [31:0] inst, input logic dr);
        u_if.flush     = fl;
        u_if.enq_valid = ev;
        u_if.enq_pc    = pc;
        u_if.enq_inst  = inst;
        u_if.deq_ready = dr;
    endtask

    function automatic vec_t mk(input logic fl, input logic ev, input logic [31:0] pc,
                                input logic dr, input logic byp, input logic er,
                                input logic dv, input logic [31:0] dpc, input logic [2:0] cnt);
        vec_t v;
        v.flush = fl; v.enq_valid = ev; v.enq_pc = pc; v.deq_ready = dr; v.byp = byp;
        v.enq_inst = (pc == 32'h100) ? 32'h2402000A : (32'hA000_0000 | pc);
        v.exp_enq_ready = er; v.exp_deq_valid = dv; v.exp_deq_pc = dpc;
        v.exp_deq_inst = !dv ? 32'h0 :
                         (dpc == 32'h100) ? 32'h2402000A : (32'hA000_0000 | dpc);
        v.exp_count = cnt;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        //          fl  ev  pc       dr  byp er  dv  dpc      cnt
        vecs[0]  = mk(0, 0, 32'h000, 0, 0,  1,  0,  32'h000, 3'd0);
        vecs[1]  = mk(0, 1, 32'h100, 0, 1,  1,  0,  32'h000, 3'd0);
        vecs[2]  = mk(0, 0, 32'h000, 1, 0,  1,  1,  32'h100, 3'd1);
        vecs[3]  = mk(0, 0, 32'h000, 0, 0,  1,  0,  32'h000, 3'd0);
        vecs[4]  = mk(0, 1, 32'h000, 0, 1,  1,  0,  32'h000, 3'd0);
        vecs[5]  = mk(0, 1, 32'h004, 0, 0,  1,  1,  32'h000, 3'd1);
        vecs[6]  = mk(0, 1, 32'h008, 0, 0,  1,  1,  32'h000, 3'd2);
        vecs[7]  = mk(0, 1, 32'h00C, 0, 0,  1,  1,  32'h000, 3'd3);
        vecs[8]  = mk(0, 1, 32'h010, 0, 0,  0,  1,  32'h000, 3'd4);
        vecs[9]  = mk(0, 1, 32'h010, 0, 0,  0,  1,  32'h000, 3'd4);
        vecs[10] = mk(0, 1, 32'h010, 1, 0,  0,  1,  32'h000, 3'd4);
        vecs[11] = mk(0, 1, 32'h010, 1, 0,  1,  1,  32'h004, 3'd3);
        vecs[12] = mk(0, 0, 32'h000, 1, 0,  1,  1,  32'h008, 3'd3);
        vecs[13] = mk(0, 0, 32'h000, 1, 0,  1,  1,  32'h00C, 3'd2);
        vecs[14] = mk(0, 0, 32'h000, 1, 0,  1,  1,  32'h010, 3'd1);
        vecs[15] = mk(0, 0, 32'h000, 0, 0,  1,  0,  32'h000, 3'd0);
        vecs[16] = mk(0, 1, 32'h020, 0, 1,  1,  0,  32'h000, 3'd0);
        vecs[17] = mk(0, 1, 32'h024, 0, 0,  1,  1,  32'h020, 3'd1);
        vecs[18] = mk(0, 1, 32'h028, 0, 0,  1,  1,  32'h020, 3'd2);
        vecs[19] = mk(1, 1, 32'h02C, 1, 0,  1,  1,  32'h020, 3'd3);
        vecs[20] = mk(0, 0, 32'h000, 1, 0,  1,  0,  32'h000, 3'd0);
        vecs[21] = mk(0, 0, 32'h000, 1, 0,  1,  0,  32'h000, 3'd0);

        // Reset state while held in reset
        @(posedge clk);
        @(negedge clk);
        chk("rst_count",     32'(u_if.count),     32'd0);
        chk("rst_deq_valid", 32'(u_if.deq_valid), 32'd0);
        chk("rst_deq_pc",    u_if.deq_pc,         32'h0);
        chk("rst_deq_inst",  u_if.deq_inst,       32'h0);
        chk("rst_enq_ready", 32'(u_if.enq_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 22; i++) begin
            logic        e_dv;
            logic [31:0] e_pc;
            logic [31:0] e_inst;
            drive(vecs[i].flush, vecs[i].enq_valid, vecs[i].enq_pc,
                  vecs[i].enq_inst, vecs[i].deq_ready);
            e_dv   = vecs[i].exp_deq_valid;
            e_pc   = vecs[i].exp_deq_pc;
            e_inst = vecs[i].exp_deq_inst;
`ifdef IFQ_BYPASS_EN
            if (vecs[i].byp) begin
                e_dv   = 1'b1;
                e_pc   = vecs[i].enq_pc;
                e_inst = vecs[i].enq_inst;
            end
`endif
            @(negedge clk);
            chk($sformatf("v%0d_enq_ready", i), 32'(u_if.enq_ready), 32'(vecs[i].exp_enq_ready));
            chk($sformatf("v%0d_deq_valid", i), 32'(u_if.deq_valid), 32'(e_dv));
            chk($sformatf("v%0d_deq_pc", i),    u_if.deq_pc,         e_pc);
            chk($sformatf("v%0d_deq_inst", i),  u_if.deq_inst,       e_inst);
            chk($sformatf("v%0d_count", i),     32'(u_if.count),     32'(vecs[i].exp_count));
            @(posedge clk); #1;
        end

        // Asynchronous reset mid-stream with two entries queued
        drive(1'b0, 1'b1, 32'h300, 32'hB000_0300, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'h304, 32'hB000_0304, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("ar_count_before", 32'(u_if.count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_count",     32'(u_if.count),     32'd0);
        chk("ar_deq_valid", 32'(u_if.deq_valid), 32'd0);
        chk("ar_enq_ready", 32'(u_if.enq_ready), 32'd1);
        chk("ar_deq_pc",    u_if.deq_pc,         32'h0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Enqueue into empty queue with decode ready
        drive(1'b0, 1'b1, 32'h200, 32'h3C01_0200, 1'b1);
        @(negedge clk);
`ifdef IFQ_BYPASS_EN
        chk("byp_deq_valid", 32'(u_if.deq_valid), 32'd1);
        chk("byp_deq_pc",    u_if.deq_pc,         32'h200);
        chk("byp_deq_inst",  u_if.deq_inst,       32'h3C01_0200);
        chk("byp_count",     32'(u_if.count),     32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        chk("byp_count_after", 32'(u_if.count),     32'd0);
        chk("byp_dv_after",    32'(u_if.deq_valid), 32'd0);
`else
        chk("nobyp_deq_valid", 32'(u_if.deq_valid), 32'd0);
        chk("nobyp_count",     32'(u_if.count),     32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        chk("nobyp_dv_next",   32'(u_if.deq_valid), 32'd1);
        chk("nobyp_pc_next",   u_if.deq_pc,         32'h200);
        chk("nobyp_inst_next", u_if.deq_inst,       32'h3C01_0200);
        chk("nobyp_cnt_next",  32'(u_if.count),     32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("nobyp_cnt_drain", 32'(u_if.count),     32'd0);
        chk("nobyp_dv_drain",  32'(u_if.deq_valid), 32'd0);
`endif
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
